// File: rtl/gate_pkg.sv
// Shared defaults for the Step 1 gate library primitives.
package gate_pkg;

  localparam int GATE_W    = 1;
  localparam int DBG_CNT_W = 8;

endpackage

// File: rtl/not_cell.sv
// Single-bit combinational inverter cell.
module not_cell (
  input  logic a,
  output logic y
);

  assign y = ~a;

endmodule

// File: rtl/not_1b.sv
// Bit-wise inverter with a combinational output, a flopped copy and a
// saturating input-toggle counter for datapath debug.
module not_1b
  import gate_pkg::*;
#(
  parameter int WIDTH = GATE_W,
  parameter int CNT_W = DBG_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             valid_q,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] inv;
  logic [WIDTH-1:0] x_prev;
  logic             toggled;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    not_cell u_cell (
      .a (x[gi]),
      .y (inv[gi])
    );
  end

  assign out = inv;

  // Any number of changed bits counts as a single toggle for the cycle.
  assign toggled = valid_q && (x != x_prev);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      valid_q    <= 1'b0;
      x_prev     <= '0;
      toggle_cnt <= '0;
    end else begin
      out_q   <= inv;
      valid_q <= 1'b1;
      x_prev  <= x;
      if (toggled && (toggle_cnt != CNT_MAX)) begin
        toggle_cnt <= toggle_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_not_1b.sv
// Directed bench for not_1b: default, 2-bit-counter and 4-bit-wide instances.
module tb_not_1b;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       x_a, out_a, outq_a, valid_a;
  logic [7:0] cnt_a;
  logic       x_s, out_s, outq_s, valid_s;
  logic [1:0] cnt_s;
  logic [3:0] x_w, out_w, outq_w;
  logic       valid_w;
  logic [7:0] cnt_w;

  int checks = 0;
  int errors = 0;

  not_1b u_a (
    .clk (clk), .rst (rst), .x (x_a), .out (out_a),
    .out_q (outq_a), .valid_q (valid_a), .toggle_cnt (cnt_a)
  );

  not_1b #(.WIDTH(1), .CNT_W(2)) u_s (
    .clk (clk), .rst (rst), .x (x_s), .out (out_s),
    .out_q (outq_s), .valid_q (valid_s), .toggle_cnt (cnt_s)
  );

  not_1b #(.WIDTH(4), .CNT_W(8)) u_w (
    .clk (clk), .rst (rst), .x (x_w), .out (out_w),
    .out_q (outq_w), .valid_q (valid_w), .toggle_cnt (cnt_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int tv[5];
    int ta[6];
    tv = '{0, 1, 0, 1, 1};
    ta = '{0, 1, 0, 1, 1, 1};
    rst = 1'b1;
    x_a = 1'b0;
    x_s = 1'b0;
    x_w = 4'b0000;

    // combinational truth table, x changes every 10 time units
    $monitor("t=%0t x=%b out=%b", $time, x_a, out_a);
    for (int i = 0; i < 5; i++) begin
      x_a = tv[i][0];
      #1;
      chk("truth", 32'(out_a), (tv[i] == 0) ? 32'd1 : 32'd0);
      #9;
    end
    $monitoroff;

    // reset held for two edges with x=1
    x_a = 1'b1;
    #1;
    chk("rst_out", 32'(out_a), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_outq", 32'(outq_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_outq", 32'(outq_a), 32'd0);
    chk("post_rst_valid", 32'(valid_a), 32'd1);

    // latency: out moves at once, out_q only on the next edge
    @(negedge clk);
    x_a = 1'b0;
    @(posedge clk);
    #1;
    chk("lat_outq_hi", 32'(outq_a), 32'd1);
    @(negedge clk);
    x_a = 1'b1;
    #1;
    chk("lat_out_now", 32'(out_a), 32'd0);
    chk("lat_outq_hold", 32'(outq_a), 32'd1);
    @(posedge clk);
    #1;
    chk("lat_outq_lo", 32'(outq_a), 32'd0);
    chk("pre_mid_cnt", 32'(cnt_a), 32'd2);

    // reset mid-operation
    @(negedge clk);
    rst = 1'b1;
    x_a = 1'b0;
    #1;
    chk("mid_out", 32'(out_a), 32'd1);
    @(posedge clk);
    #1;
    chk("mid_outq", 32'(outq_a), 32'd0);
    chk("mid_valid", 32'(valid_a), 32'd0);
    chk("mid_cnt", 32'(cnt_a), 32'd0);

    // toggle counting on u_a, saturation on u_s
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      x_a = ta[i][0];
      x_s = i[0];
      @(negedge clk);
    end
    chk("tog_cnt", 32'(cnt_a), 32'd3);
    chk("sat_cnt", 32'(cnt_s), 32'd3);
    for (int i = 0; i < 4; i++) begin
      x_s = ~x_s;
      @(negedge clk);
    end
    chk("sat_hold", 32'(cnt_s), 32'd3);
    chk("tog_hold", 32'(cnt_a), 32'd3);

    // wide instance
    chk("wide_cnt0", 32'(cnt_w), 32'd0);
    x_w = 4'b1010;
    #1;
    chk("wide_out", 32'(out_w), 32'h5);
    @(posedge clk);
    #1;
    chk("wide_outq", 32'(outq_w), 32'h5);
    chk("wide_cnt1", 32'(cnt_w), 32'd1);
    @(negedge clk);
    x_w = 4'b0101;
    #1;
    chk("wide_out2", 32'(out_w), 32'hA);
    @(posedge clk);
    #1;
    chk("wide_outq2", 32'(outq_w), 32'hA);
    chk("wide_cnt2", 32'(cnt_w), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
